// File: rtl/sram22_param_model.sv
// sram22_param_model: behavioural single-port SRAM with a power-up clear engine.
//
// After reset the CLEAR state walks every word and writes zero, one word per
// clock, holding busy high and ignoring all access requests. In IDLE the
// macro serves one access per clock: masked writes (lane i covers bits
// [i*LW +: LW]) and registered reads with latency 1.
//
// Optional build macro: SRAM22_OUT_REG_EN adds one more output register stage
// (read latency 2); dout/dout_valid of that stage also reset to zero.
//
// Ports:
//   clk        clock, rising edge
//   rstb       asynchronous active-low reset
//   en         access enable
//   we         1 = write, 0 = read (qualified by en)
//   wmask      per-lane write enable
//   addr       word address
//   din        write data
//   dout       registered read data
//   dout_valid one-cycle pulse per dout update from an access
//   busy       high while the clear engine runs
module sram22_param_model #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int WMASK_WIDTH   = 4,
  parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
  parameter int WRITE_THROUGH = 0
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   en,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   busy
);

  localparam int LW = DATA_WIDTH / WMASK_WIDTH;
  // Index width sized to the array so narrow-depth builds index cleanly.
  localparam int MW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    dv_q, dv_d;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  logic                    mem_we;
  logic [MW-1:0]           mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    in_range;
  logic [MW-1:0]           addr_idx;

  assign addr_idx = addr[MW-1:0];
  assign in_range = {1'b0, addr} < (ADDR_WIDTH+1)'(RAM_DEPTH);
  assign rd_word  = in_range ? mem[addr_idx] : '0;

  always_comb begin
    merged = rd_word;
    for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
      if (wmask[i]) merged[i*LW +: LW] = din[i*LW +: LW];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    dv_d      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_idx;
    mem_wdata = merged;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[MW-1:0];
        mem_wdata = '0;
        if (cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        if (en) begin
          if (we) begin
            // Out-of-range writes are dropped; write-through then reports the
            // all-zero word an out-of-range read would return.
            mem_we = in_range && (|wmask);
            if (WRITE_THROUGH != 0) begin
              dout_d = in_range ? merged : '0;
              dv_d   = 1'b1;
            end
          end else begin
            dout_d = rd_word;
            dv_d   = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign busy = (state_q == CLEAR);

`ifdef SRAM22_OUT_REG_EN
  logic [DATA_WIDTH-1:0] dout2_q;
  logic                  dv2_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dout2_q <= '0;
      dv2_q   <= 1'b0;
    end else begin
      dout2_q <= dout_q;
      dv2_q   <= dv_q;
    end
  end

  assign dout       = dout2_q;
  assign dout_valid = dv2_q;
`else
  assign dout       = dout_q;
  assign dout_valid = dv_q;
`endif

endmodule

// File: tb/tb_sram22_param_model.sv
module tb_sram22_param_model;

`ifdef SRAM22_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rstb;
  logic        en;
  logic        we;
  logic [3:0]  wmask;
  logic [9:0]  addr;
  logic [31:0] din;
  logic [31:0] dout_a, dout_b;
  logic        dv_a, dv_b, busy_a, busy_b;

  int passed = 0;
  int total  = 0;

  // A: default build (1024 words, no write-through).
  sram22_param_model dut_a (
    .clk(clk), .rstb(rstb), .en(en), .we(we), .wmask(wmask), .addr(addr),
    .din(din), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a)
  );

  // B: write-through, 16 words so addresses >= 16 are out of range.
  sram22_param_model #(.WRITE_THROUGH(1), .RAM_DEPTH(16)) dut_b (
    .clk(clk), .rstb(rstb), .en(en), .we(we), .wmask(wmask), .addr(addr),
    .din(din), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        we;
    logic [3:0]  wmask;
    logic [9:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_a;
    logic        dv_a;
    logic [31:0] exp_b;
    logic        dv_b;
    logic        chk_b;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic idle_inputs();
    en = 1'b0; we = 1'b0; wmask = '0; addr = '0; din = '0;
  endtask

  // Release reset, then count cycles until each busy falls. Optionally
  // issue a write to addr 3 while both engines are still clearing.
  task automatic measure_clear(input bit poke, output int fa, output int fb, output int bad);
    fa = -1; fb = -1; bad = 0;
    @(negedge clk);
    rstb = 1'b1;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk);
      #1;
      if (poke && k == 1) begin
        en = 1'b1; we = 1'b1; wmask = 4'hF; addr = 10'd3; din = 32'hFFFF_FFFF;
      end
      if (poke && k == 5) idle_inputs();
      if (fa < 0 && !busy_a) fa = k;
      if (fb < 0 && !busy_b) fb = k;
      if (busy_a && (dv_a || dout_a != 32'h0)) bad++;
      if (busy_b && (dv_b || dout_b != 32'h0)) bad++;
      if (fa >= 0 && fb >= 0) break;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    en = v.en; we = v.we; wmask = v.wmask; addr = v.addr; din = v.din;
    @(posedge clk);
    #1;
    idle_inputs();
    if (LAT > 1) begin
      repeat (LAT - 1) @(posedge clk);
      #1;
    end
    chk($sformatf("vec%0d dout_a", idx), dout_a, v.exp_a);
    chk($sformatf("vec%0d dv_a", idx), {31'b0, dv_a}, {31'b0, v.dv_a});
    if (v.chk_b) chk($sformatf("vec%0d dout_b", idx), dout_b, v.exp_b);
    chk($sformatf("vec%0d dv_b", idx), {31'b0, dv_b}, {31'b0, v.dv_b});
  endtask

  initial begin
    int fa, fb, bad;
    logic [31:0] burst [3];

    //            en   we   mask   addr     din           exp_a        dva  exp_b        dvb  chkb
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0,        32'h0,        1'b1, 32'h0,        1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 10'd3,   32'h0,        32'h0,        1'b1, 32'h0,        1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 4'h5, 10'd5,   32'hAABBCCDD, 32'h0,        1'b0, 32'h00BB00DD, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 10'd5,   32'h0,        32'h00BB00DD, 1'b1, 32'h00BB00DD, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 4'hF, 10'd7,   32'h12345678, 32'h00BB00DD, 1'b0, 32'h12345678, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 10'd7,   32'h0,        32'h12345678, 1'b1, 32'h12345678, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 4'h0, 10'd7,   32'hFFFFFFFF, 32'h12345678, 1'b0, 32'h12345678, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 10'd7,   32'h0,        32'h12345678, 1'b1, 32'h12345678, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 4'h8, 10'd7,   32'hCAFEF00D, 32'h12345678, 1'b0, 32'hCA345678, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 4'hF, 10'd7,   32'h0,        32'h12345678, 1'b0, 32'hCA345678, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 10'd7,   32'h0,        32'hCA345678, 1'b1, 32'hCA345678, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 4'hF, 10'd20,  32'hDEADBEEF, 32'hCA345678, 1'b0, 32'h0,        1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 10'd20,  32'h0,        32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 10'd4,   32'h0,        32'h0,        1'b1, 32'h0,        1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 4'hF, 10'd1,   32'h11,       32'h0,        1'b0, 32'h11,       1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 4'hF, 10'd2,   32'h22,       32'h0,        1'b0, 32'h22,       1'b1, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 4'hF, 10'd3,   32'h33,       32'h0,        1'b0, 32'h33,       1'b1, 1'b1};
    burst[0] = 32'h11; burst[1] = 32'h22; burst[2] = 32'h33;

    idle_inputs();
    rstb = 1'b1;
    #1 rstb = 1'b0;
    #2;
    chk("reset busy_a", {31'b0, busy_a}, 32'd1);
    chk("reset dout_a", dout_a, 32'h0);
    chk("reset dv_a", {31'b0, dv_a}, 32'd0);
    chk("reset busy_b", {31'b0, busy_b}, 32'd1);
    chk("reset dout_b", dout_b, 32'h0);
    chk("reset dv_b", {31'b0, dv_b}, 32'd0);

    // Reset pulse in the middle of the clear restarts it from address 0.
    @(negedge clk);
    rstb = 1'b1;
    repeat (500) @(posedge clk);
    #3 rstb = 1'b0;
    #1;
    chk("midclear busy_a", {31'b0, busy_a}, 32'd1);
    chk("midclear dout_a", dout_a, 32'h0);
    chk("midclear busy_b", {31'b0, busy_b}, 32'd1);

    measure_clear(1'b1, fa, fb, bad);
    chk("clear cycles a", fa, 32'd1024);
    chk("clear cycles b", fb, 32'd16);
    chk("outputs quiet in clear", bad, 32'd0);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Back-to-back reads of 1,2,3: valid stays high, one new word per cycle.
    for (int c = 0; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c < 3) begin
        en = 1'b1; we = 1'b0; addr = 10'(c + 1);
      end else begin
        idle_inputs();
      end
      @(posedge clk);
      #1;
      if (c >= LAT - 1) begin
        chk($sformatf("burst%0d dout_a", c - LAT + 1), dout_a, burst[c - LAT + 1]);
        chk($sformatf("burst%0d dv_a", c - LAT + 1), {31'b0, dv_a}, 32'd1);
        chk($sformatf("burst%0d dout_b", c - LAT + 1), dout_b, burst[c - LAT + 1]);
      end
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("burst end dv_a", {31'b0, dv_a}, 32'd0);

    // Reset during a read: in-flight data discarded, memory cleared again.
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = 10'd2;
    @(posedge clk);
    #2 rstb = 1'b0;
    idle_inputs();
    #1;
    chk("midaccess dout_a", dout_a, 32'h0);
    chk("midaccess dv_a", {31'b0, dv_a}, 32'd0);
    chk("midaccess busy_a", {31'b0, busy_a}, 32'd1);
    chk("midaccess dout_b", dout_b, 32'h0);
    measure_clear(1'b0, fa, fb, bad);
    chk("reclear cycles a", fa, 32'd1024);
    run_vec(100, '{1'b1, 1'b0, 4'h0, 10'd2, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
